// File: rtl/credit_fifo_mc.sv
// credit_fifo_mc: NCH per-channel FIFOs, each gated by its own downstream credit counter,
//    sharing one output port through a round-robin arbiter.
// Latency: push to earliest issue is 1 cycle; issue is combinational from registered state.
// Backpressure: out_rdy=0 stalls issue; credit exhaustion parks a channel; push while full drops.
//
// Ports:
//    clk, rst       clock, asynchronous active-high reset
//    push, data_in  per-channel write strobe and data (channel c at [c*WIDTH +: WIDTH])
//    credit_return  per-channel +1 credit from the downstream receive buffers
//    out_rdy        downstream accepts the offered entry this cycle
//    full, empty    per-channel FIFO status
//    out_vld, out_ch, data_out  offered entry and its channel (zero when nothing is eligible)
//    credit_err, ovf_err        sticky error flags, cleared only by rst

// credit_fifo_mc_fifo: circular buffer with separate occupancy count.
// Latency: written entry is visible at the head on the following cycle.
// Backpressure: caller must gate i_wr with !o_full and i_rd with !o_empty.
module credit_fifo_mc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_dat,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rd_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;

   // Storage carries no reset; the head is only consumed when the count says it is valid.
   always_ff @(posedge clk) begin
      if (i_wr) begin
         r_mem[r_wr_ptr] <= i_wr_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_wr, i_rd})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_rd_dat = r_mem[r_rd_ptr];
   assign o_full   = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty  = (r_cnt == '0);
endmodule

module credit_fifo_mc #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int NCH      = 4,
   parameter int DS_DEPTH = 4,
   parameter int CHW      = $clog2(NCH),
   parameter int CW       = $clog2(DS_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       push,
   input  logic [NCH*WIDTH-1:0] data_in,
   input  logic [NCH-1:0]       credit_return,
   input  logic                 out_rdy,
   output logic [NCH-1:0]       full,
   output logic [NCH-1:0]       empty,
   output logic                 out_vld,
   output logic [CHW-1:0]       out_ch,
   output logic [WIDTH-1:0]     data_out,
   output logic                 credit_err,
   output logic                 ovf_err
);
   logic [NCH-1:0]   w_full;
   logic [NCH-1:0]   w_empty;
   logic [NCH-1:0]   w_elig;
   logic [NCH-1:0]   w_wr;
   logic [NCH-1:0]   w_rd;
   logic [NCH-1:0]   w_cr_ovf;
   logic [WIDTH-1:0] w_head [NCH];
   logic [CW-1:0]    r_credit [NCH];
   logic [CHW-1:0]   r_ptr;
   logic [CHW-1:0]   w_gnt;
   logic [CHW-1:0]   w_idx;
   logic [CHW:0]     w_sum;
   logic             w_gnt_vld;
   logic             w_issue;
   logic             r_credit_err;
   logic             r_ovf_err;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      credit_fifo_mc_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .i_wr     (w_wr[c]),
         .i_wr_dat (data_in[c*WIDTH +: WIDTH]),
         .i_rd     (w_rd[c]),
         .o_rd_dat (w_head[c]),
         .o_full   (w_full[c]),
         .o_empty  (w_empty[c])
      );

      // A push into a full FIFO is dropped even if the same channel pops this cycle.
      assign w_wr[c]     = push[c] & ~w_full[c];
      assign w_elig[c]   = ~w_empty[c] & (r_credit[c] != '0);
      assign w_rd[c]     = w_issue & (w_gnt == CHW'(c));
      // A return with no matching issue on a channel already holding every credit is bogus.
      assign w_cr_ovf[c] = credit_return[c] & ~w_rd[c] & (r_credit[c] == CW'(DS_DEPTH));
   end

   // Round-robin scan starting at r_ptr; the modulo is folded into one conditional subtract.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = 0; i < NCH; i++) begin
         w_sum = {1'b0, r_ptr} + (CHW+1)'(i);
         if (w_sum >= (CHW+1)'(NCH)) begin
            w_sum = w_sum - (CHW+1)'(NCH);
         end
         w_idx = w_sum[CHW-1:0];
         if (!w_gnt_vld && w_elig[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx;
         end
      end
   end

   assign w_issue  = w_gnt_vld & out_rdy;
   assign out_vld  = w_gnt_vld;
   assign out_ch   = w_gnt;
   assign data_out = w_gnt_vld ? w_head[w_gnt] : '0;
   assign full     = w_full;
   assign empty    = w_empty;

   // Pointer moves only on an issue, to the channel after the one just served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_issue) begin
         r_ptr <= (w_gnt == CHW'(NCH-1)) ? '0 : w_gnt + 1'b1;
      end
   end

   // Issue and return in the same cycle cancel; decrement at zero cannot occur since
   // a channel without credit is never eligible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_credit[c] <= CW'(DS_DEPTH);
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_rd[c] && !credit_return[c]) begin
               r_credit[c] <= r_credit[c] - 1'b1;
            end else if (!w_rd[c] && credit_return[c] && (r_credit[c] != CW'(DS_DEPTH))) begin
               r_credit[c] <= r_credit[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credit_err <= 1'b0;
         r_ovf_err    <= 1'b0;
      end else begin
         if (|w_cr_ovf) begin
            r_credit_err <= 1'b1;
         end
         if (|(push & w_full)) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

   assign credit_err = r_credit_err;
   assign ovf_err    = r_ovf_err;
endmodule

// File: tb/tb_credit_fifo_mc.sv
// tb_credit_fifo_mc: directed scenarios for the multi-channel credit FIFO.
// Latency: inputs change 1 time unit after posedge, outputs are sampled on negedge.
// Backpressure: out_rdy and credit_return are driven explicitly per scenario.
module tb_credit_fifo_mc;
   localparam int WIDTH    = 8;
   localparam int DEPTH    = 4;
   localparam int NCH      = 4;
   localparam int DS_DEPTH = 4;
   localparam int CHW      = 2;
   localparam int CW       = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       push;
   logic [NCH*WIDTH-1:0] data_in;
   logic [NCH-1:0]       credit_return;
   logic                 out_rdy;
   logic [NCH-1:0]       full;
   logic [NCH-1:0]       empty;
   logic                 out_vld;
   logic [CHW-1:0]       out_ch;
   logic [WIDTH-1:0]     data_out;
   logic                 credit_err;
   logic                 ovf_err;

   int n_pass  = 0;
   int n_total = 0;

   credit_fifo_mc #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NCH      (NCH),
      .DS_DEPTH (DS_DEPTH),
      .CHW      (CHW),
      .CW       (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .push          (push),
      .data_in       (data_in),
      .credit_return (credit_return),
      .out_rdy       (out_rdy),
      .full          (full),
      .empty         (empty),
      .out_vld       (out_vld),
      .out_ch        (out_ch),
      .data_out      (data_out),
      .credit_err    (credit_err),
      .ovf_err       (ovf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      push          = '0;
      data_in       = '0;
      credit_return = '0;
      out_rdy       = 1'b0;
   endtask

   task automatic set_push(input int ch, input logic [WIDTH-1:0] d);
      push[ch]                    = 1'b1;
      data_in[ch*WIDTH +: WIDTH]  = d;
   endtask

   // Leaves the bench at a negedge with rst released.
   task automatic do_reset();
      rst = 1'b1;
      clr_in();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_total++;
      if ({full, empty} !== 8'h0F) $display("FAIL reset_flags: got %h expected %h", {full, empty}, 8'h0F);
      else n_pass++;
      n_total++;
      if ({out_vld, out_ch, data_out} !== 11'h0) $display("FAIL reset_out: got %h expected %h", {out_vld, out_ch, data_out}, 11'h0);
      else n_pass++;
      n_total++;
      if ({credit_err, ovf_err} !== 2'b00) $display("FAIL reset_err: got %b expected %b", {credit_err, ovf_err}, 2'b00);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_push_issue();
      do_reset();
      tick(); out_rdy = 1'b1; set_push(0, 8'h11); @(negedge clk);
      n_total++;
      if (out_vld !== 1'b0) $display("FAIL first_push_latency: got vld=%b expected 0", out_vld);
      else n_pass++;
      tick(); set_push(0, 8'h22); @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd0, 8'h11}) $display("FAIL issue_11: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd0, 8'h11});
      else n_pass++;
      tick(); push = '0; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd0, 8'h22}) $display("FAIL issue_22: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd0, 8'h22});
      else n_pass++;
      tick(); @(negedge clk);
      n_total++;
      if ({out_vld, empty} !== 5'b0_1111) $display("FAIL drained: got %b expected %b", {out_vld, empty}, 5'b0_1111);
      else n_pass++;
      // Two issues leave credit0 at 2: two returns are legal, a third is an error.
      tick(); out_rdy = 1'b0; credit_return = 4'b0001; tick(); tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if (credit_err !== 1'b0) $display("FAIL credit_restore: got credit_err=%b expected 0", credit_err);
      else n_pass++;
      tick(); credit_return = 4'b0001; tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if (credit_err !== 1'b1) $display("FAIL credit_extra_return: got credit_err=%b expected 1", credit_err);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [CHW-1:0]   ec;
      logic [WIDTH-1:0] ed;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         tick();
         for (int c = 0; c < NCH; c++) set_push(c, 8'(c*16 + k + 1));
         @(negedge clk);
      end
      tick(); push = '0; out_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ec = 2'(i % 4);
         ed = 8'((i % 4)*16 + i/4 + 1);
         n_total++;
         if ({out_vld, out_ch, data_out} !== {1'b1, ec, ed}) $display("FAIL rr_issue_%0d: got %h expected %h", i, {out_vld, out_ch, data_out}, {1'b1, ec, ed});
         else n_pass++;
         tick();
      end
      @(negedge clk);
      n_total++;
      if ({out_vld, empty} !== 5'b0_1111) $display("FAIL rr_drained: got %b expected %b", {out_vld, empty}, 5'b0_1111);
      else n_pass++;
   endtask

   task automatic test_credit_limit();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick(); set_push(1, 8'(8'hB0 + k)); @(negedge clk);
      end
      tick(); push = '0; out_rdy = 1'b1; @(negedge clk);
      n_total++;
      if ({full[1], out_vld, out_ch, data_out} !== {1'b1, 1'b1, 2'd1, 8'hB0}) $display("FAIL cl_issue_b0: got %h expected %h", {full[1], out_vld, out_ch, data_out}, {1'b1, 1'b1, 2'd1, 8'hB0});
      else n_pass++;
      tick(); set_push(1, 8'hB4); @(negedge clk);
      n_total++;
      if (data_out !== 8'hB1) $display("FAIL cl_issue_b1: got %h expected %h", data_out, 8'hB1);
      else n_pass++;
      tick(); set_push(1, 8'hB5); @(negedge clk);
      n_total++;
      if (data_out !== 8'hB2) $display("FAIL cl_issue_b2: got %h expected %h", data_out, 8'hB2);
      else n_pass++;
      tick(); push = '0; @(negedge clk);
      n_total++;
      if (data_out !== 8'hB3) $display("FAIL cl_issue_b3: got %h expected %h", data_out, 8'hB3);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         tick(); @(negedge clk);
         n_total++;
         if ({out_vld, empty[1]} !== 2'b00) $display("FAIL cl_out_of_credit_%0d: got %b expected %b", i, {out_vld, empty[1]}, 2'b00);
         else n_pass++;
      end
      tick(); credit_return = 4'b0010; @(negedge clk);
      n_total++;
      if (out_vld !== 1'b0) $display("FAIL cl_return_cycle: got vld=%b expected 0", out_vld);
      else n_pass++;
      tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd1, 8'hB4}) $display("FAIL cl_one_more: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd1, 8'hB4});
      else n_pass++;
      tick(); @(negedge clk);
      n_total++;
      if ({out_vld, empty[1], credit_err} !== 3'b000) $display("FAIL cl_parked_again: got %b expected %b", {out_vld, empty[1], credit_err}, 3'b000);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick(); set_push(2, 8'(8'hA0 + k)); @(negedge clk);
      end
      tick(); set_push(2, 8'hAA); @(negedge clk);
      n_total++;
      if ({full[2], ovf_err} !== 2'b10) $display("FAIL ovf_before: got %b expected %b", {full[2], ovf_err}, 2'b10);
      else n_pass++;
      tick(); push = '0; out_rdy = 1'b1; @(negedge clk);
      n_total++;
      if ({ovf_err, out_vld, out_ch, data_out} !== {1'b1, 1'b1, 2'd2, 8'hA0}) $display("FAIL ovf_set: got %h expected %h", {ovf_err, out_vld, out_ch, data_out}, {1'b1, 1'b1, 2'd2, 8'hA0});
      else n_pass++;
      for (int k = 1; k < 4; k++) begin
         tick(); @(negedge clk);
         n_total++;
         if ({out_vld, out_ch, data_out} !== {1'b1, 2'd2, 8'(8'hA0 + k)}) $display("FAIL ovf_drain_%0d: got %h expected %h", k, {out_vld, out_ch, data_out}, {1'b1, 2'd2, 8'(8'hA0 + k)});
         else n_pass++;
      end
      tick(); @(negedge clk);
      n_total++;
      if ({out_vld, empty[2]} !== 2'b01) $display("FAIL ovf_dropped: got %b expected %b", {out_vld, empty[2]}, 2'b01);
      else n_pass++;
      tick(); out_rdy = 1'b0; credit_return = 4'b0100; repeat (3) tick(); tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if (credit_err !== 1'b0) $display("FAIL ovf_credit_refill: got credit_err=%b expected 0", credit_err);
      else n_pass++;
      tick(); set_push(2, 8'h51); @(negedge clk);
      tick(); set_push(2, 8'h52); out_rdy = 1'b1; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd2, 8'h51}) $display("FAIL pushpop_issue: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd2, 8'h51});
      else n_pass++;
      tick(); push = '0; out_rdy = 1'b0; @(negedge clk);
      n_total++;
      if ({out_vld, data_out, full[2], empty[2]} !== {1'b1, 8'h52, 2'b00}) $display("FAIL pushpop_head: got %h expected %h", {out_vld, data_out, full[2], empty[2]}, {1'b1, 8'h52, 2'b00});
      else n_pass++;
      tick(); set_push(2, 8'h53); tick(); set_push(2, 8'h54); tick(); set_push(2, 8'h55); @(negedge clk);
      n_total++;
      if (full[2] !== 1'b0) $display("FAIL pushpop_count3: got full=%b expected 0", full[2]);
      else n_pass++;
      tick(); push = '0; @(negedge clk);
      n_total++;
      if (full[2] !== 1'b1) $display("FAIL pushpop_count4: got full=%b expected 1", full[2]);
      else n_pass++;
   endtask

   task automatic test_credit_err();
      do_reset();
      tick(); credit_return = 4'b1000; @(negedge clk);
      n_total++;
      if (credit_err !== 1'b0) $display("FAIL cerr_before: got %b expected 0", credit_err);
      else n_pass++;
      tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if (credit_err !== 1'b1) $display("FAIL cerr_set: got %b expected 1", credit_err);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         tick(); set_push(3, 8'(8'h30 + k)); @(negedge clk);
      end
      tick(); push = '0; out_rdy = 1'b1; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd3, 8'h30}) $display("FAIL cerr_issue_30: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd3, 8'h30});
      else n_pass++;
      tick(); set_push(3, 8'h34); @(negedge clk);
      tick(); set_push(3, 8'h35); @(negedge clk);
      tick(); push = '0; @(negedge clk);
      n_total++;
      if (data_out !== 8'h33) $display("FAIL cerr_issue_33: got %h expected %h", data_out, 8'h33);
      else n_pass++;
      tick(); @(negedge clk);
      n_total++;
      if ({out_vld, empty[3]} !== 2'b00) $display("FAIL cerr_saturated: got %b expected %b", {out_vld, empty[3]}, 2'b00);
      else n_pass++;

      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick(); set_push(0, 8'(8'h61 + k)); @(negedge clk);
      end
      tick(); push = '0; out_rdy = 1'b1; credit_return = 4'b0001; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd0, 8'h61}) $display("FAIL both_issue_61: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd0, 8'h61});
      else n_pass++;
      tick(); credit_return = '0; @(negedge clk);
      n_total++;
      if ({credit_err, data_out} !== {1'b0, 8'h62}) $display("FAIL both_no_err: got %h expected %h", {credit_err, data_out}, {1'b0, 8'h62});
      else n_pass++;
      tick(); tick(); @(negedge clk);
      n_total++;
      if (data_out !== 8'h64) $display("FAIL both_issue_64: got %h expected %h", data_out, 8'h64);
      else n_pass++;
      tick(); out_rdy = 1'b0; set_push(0, 8'h65); tick(); set_push(0, 8'h66); tick(); push = '0; out_rdy = 1'b1; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd0, 8'h65}) $display("FAIL both_last_credit: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd0, 8'h65});
      else n_pass++;
      tick(); @(negedge clk);
      n_total++;
      if ({out_vld, empty[0]} !== 2'b00) $display("FAIL both_credit_out: got %b expected %b", {out_vld, empty[0]}, 2'b00);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      tick(); push = 4'hF; data_in = 32'h44332211; @(negedge clk);
      tick(); push = '0; out_rdy = 1'b1; credit_return = 4'b0010; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out} !== {1'b1, 2'd0, 8'h11}) $display("FAIL ar_pre_issue: got %h expected %h", {out_vld, out_ch, data_out}, {1'b1, 2'd0, 8'h11});
      else n_pass++;
      tick(); out_rdy = 1'b0; credit_return = '0; @(negedge clk);
      n_total++;
      if ({credit_err, out_vld, out_ch, data_out} !== {1'b1, 1'b1, 2'd1, 8'h22}) $display("FAIL ar_pre_state: got %h expected %h", {credit_err, out_vld, out_ch, data_out}, {1'b1, 1'b1, 2'd1, 8'h22});
      else n_pass++;
      #2; rst = 1'b1; #1;
      n_total++;
      if ({out_vld, out_ch, data_out, empty, full, credit_err, ovf_err} !== {11'h0, 4'hF, 4'h0, 2'b00}) $display("FAIL ar_immediate: got %h expected %h", {out_vld, out_ch, data_out, empty, full, credit_err, ovf_err}, {11'h0, 4'hF, 4'h0, 2'b00});
      else n_pass++;
      @(negedge clk); rst = 1'b0;
      tick(); push = 4'b1001; data_in = 32'h99000088; @(negedge clk);
      n_total++;
      if (out_vld !== 1'b0) $display("FAIL ar_post_latency: got vld=%b expected 0", out_vld);
      else n_pass++;
      tick(); push = '0; @(negedge clk);
      n_total++;
      if ({out_vld, out_ch, data_out, empty} !== {1'b1, 2'd0, 8'h88, 4'b0110}) $display("FAIL ar_first_grant: got %h expected %h", {out_vld, out_ch, data_out, empty}, {1'b1, 2'd0, 8'h88, 4'b0110});
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      test_reset();
      test_push_issue();
      test_round_robin();
      test_credit_limit();
      test_overflow();
      test_credit_err();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/credit_fifo_mc.md
Name: credit_fifo_mc

Overview:
- Multi-channel generalisation of the single-channel credit-gated FIFO.
- NCH independent input FIFOs, each paired with its own downstream credit counter, share one output port.
- A round-robin arbiter issues at most one entry per cycle from a channel that has both data and credits.
- Sits between upstream producers and a shared downstream link with per-channel receive buffers of DS_DEPTH entries.

Parameters:
- WIDTH, 8: data width per entry.
- DEPTH, 4: entries per channel FIFO (power of 2, >=2).
- NCH, 4: channel count (>=2).
- DS_DEPTH, 4: downstream buffer depth per channel; initial and maximum credit count.
- CHW, $clog2(NCH): channel-id width.
- CW, $clog2(DS_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- push  in  NCH  per-channel write strobe.
- data_in  in  NCH*WIDTH  channel c's data at bits [c*WIDTH +: WIDTH].
- credit_return  in  NCH  per-channel credit return, +1 credit each.
- out_rdy  in  1  downstream accepts issue this cycle.
- full  out  NCH  per-channel FIFO full.
- empty  out  NCH  per-channel FIFO empty.
- out_vld  out  1  some channel is eligible.
- out_ch  out  CHW  granted channel.
- data_out  out  WIDTH  head entry of granted channel.
- credit_err  out  1  sticky: credit return at DS_DEPTH.
- ovf_err  out  1  sticky: push while full.

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty: empty=all 1, full=all 0.
  - Credits all = DS_DEPTH; rr pointer = 0.
  - out_vld=0, out_ch=0, data_out=0; both error flags 0.
- Per-channel FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits plus an occupancy count of $clog2(DEPTH)+1 bits.
  - Pointers wrap DEPTH-1 -> 0.
  - full = (count==DEPTH); empty = (count==0); both registered-state derived.
- Push:
  - push[c] & !full[c]: write at wr_ptr, count+1.
  - Data is eligible for issue the next cycle (1-cycle min latency).
  - push[c] & full[c]: entry dropped and ovf_err set, even if channel c issues in the same cycle.
- Eligibility: elig[c] = !empty[c] & (credit[c] != 0).
- Arbitration (combinational):
  - Grant the first eligible channel scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1.
  - out_vld = |elig; out_ch = granted index; data_out = head of granted FIFO.
  - When out_vld=0: out_ch=0, data_out=0.
- Issue = out_vld & out_rdy. On issue of channel g:
  - FIFO g pops (rd_ptr+1, count-1) and credit[g] decrements.
  - ptr <= (g==NCH-1) ? 0 : g+1.
- No issue: ptr holds. Out_rdy=0 holds grant only if eligibility is unchanged; no stickiness is required.
- Credits per channel:
  - Issue only: -1. credit_return only: +1. Both in the same cycle: unchanged.
  - credit_return while credit==DS_DEPTH and no issue: saturate at DS_DEPTH and set credit_err.
  - Decrement at 0 is impossible (gated by elig).
- Simultaneous push and issue on the same non-full channel: count unchanged, both pointers advance. Empty channel cannot issue in its push cycle.
- Invariants:
  - credit[c] + (entries issued on c not yet returned) == DS_DEPTH, absent credit_err.
  - Per-channel data order preserved; no duplication or loss except ovf drops.
- Error flags clear only on rst.

Test Plan:
- Reset, then push ch0 data 0x11, 0x22, out_rdy=1 -> out_vld rises the cycle after the first push; data_out=0x11 then 0x22, out_ch=0; credit0 goes 4->3->2.
- Preload 2 entries in each of ch0..ch3, out_rdy=1 continuously -> out_ch sequence 0,1,2,3,0,1,2,3; full throughput of one issue per cycle.
- DS_DEPTH=4, ch1 holds 6 entries, no credit_return -> exactly 4 issues, then out_vld=0 with empty[1]=0. Pulse credit_return[1] once -> exactly one more issue.
- Fill ch2 to DEPTH (full[2]=1), push 0xAA again -> ovf_err=1 and 0xAA never appears on data_out. Simultaneous push and issue on non-full ch2 -> count unchanged.
- credit_return[3] with credit3=4 -> credit_err=1, credit3 stays 4. Same-cycle issue plus return on ch0 -> credit0 unchanged.
- Assert rst mid-stream with entries in all channels -> outputs clear immediately (async); after release, all empty, credits=DS_DEPTH, first grant from ch0.
